// File: rtl/gate_pkg.sv
// Shared mode encoding and mode-stepping helper for the switch/LED gate unit.
// Eight bitwise operations selected by a 3-bit mode register.
package gate_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_AND    = 3'd0;
    localparam mode_t MODE_OR     = 3'd1;
    localparam mode_t MODE_XOR    = 3'd2;
    localparam mode_t MODE_NAND   = 3'd3;
    localparam mode_t MODE_NOR    = 3'd4;
    localparam mode_t MODE_XNOR   = 3'd5;
    localparam mode_t MODE_NOT    = 3'd6;
    localparam mode_t MODE_PARITY = 3'd7;

    // Simultaneous up and down presses cancel; wrap is natural modulo-8 arithmetic.
    function automatic mode_t mode_step(input mode_t cur, input logic up, input logic dn);
        mode_t nxt;
        nxt = cur;
        if (up && !dn) begin
            nxt = cur + mode_t'(1);
        end else if (dn && !up) begin
            nxt = cur - mode_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gate_mode_unit_debouncer.sv
// Button conditioner: 2-flop synchroniser, counting debouncer and rising-edge pulse.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             q_next;
    logic             q_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            sync_meta <= din;
            sync_s    <= sync_meta;
        end
    end

    // Any agreement with the held level discards a partial count.
    always_comb begin
        cnt_next = '0;
        q_next   = q;
        if (sync_s != q) begin
            if (cnt == CNT_MAX) begin
                q_next   = sync_s;
                cnt_next = '0;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            q      <= 1'b0;
            q_prev <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            q      <= q_next;
            q_prev <= q;
        end
    end

    assign rise = q & ~q_prev;

endmodule

// File: rtl/gate_mode_unit.sv
// Board-level gate unit: synchronised switch operands, button-stepped mode register
// and a registered result mux driving the LEDs.
module gate_mode_unit
    import gate_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               BTNU,
    input  logic               BTND,
    input  logic [2*WIDTH-1:0] SW,
    output logic [WIDTH-1:0]   LD,
    output logic [MODE_W-1:0]  MODE_LD
);

    logic [2*WIDTH-1:0] sw_meta;
    logic [2*WIDTH-1:0] sw_sync;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   ld_next;
    mode_t              mode;
    logic               up_level;
    logic               up_rise;
    logic               dn_level;
    logic               dn_rise;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (BTNU),
        .q    (up_level),
        .rise (up_rise)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (BTND),
        .q    (dn_level),
        .rise (dn_rise)
    );

    // Switches are synchronised only; bounce on a switch just shows briefly on the LEDs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    assign op_a = sw_sync[WIDTH-1:0];
    assign op_b = sw_sync[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= MODE_AND;
        end else begin
            mode <= mode_step(mode, up_rise, dn_rise);
        end
    end

    always_comb begin
        ld_next = '0;
        case (mode)
            MODE_AND:    ld_next = op_a & op_b;
            MODE_OR:     ld_next = op_a | op_b;
            MODE_XOR:    ld_next = op_a ^ op_b;
            MODE_NAND:   ld_next = ~(op_a & op_b);
            MODE_NOR:    ld_next = ~(op_a | op_b);
            MODE_XNOR:   ld_next = ~(op_a ^ op_b);
            MODE_NOT:    ld_next = ~op_a;
            MODE_PARITY: ld_next[0] = ^sw_sync;
            default:     ld_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LD <= '0;
        end else begin
            LD <= ld_next;
        end
    end

    assign MODE_LD = mode;

    // A press pulse can only occur while the debounced level is high.
    a_up_rise_level: assert property (@(posedge clk) disable iff (!rst_n) up_rise |-> up_level);
    a_dn_rise_level: assert property (@(posedge clk) disable iff (!rst_n) dn_rise |-> dn_level);

endmodule

// File: tb/tb_gate_mode_unit.sv
// Self-checking bench for gate_mode_unit with WIDTH=4, DEBOUNCE_CYCLES=4.
// Expected LED/mode values are queued as stimulus is applied and drained at sample points.
module tb_gate_mode_unit;

    localparam int WIDTH = 4;
    localparam int DC    = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         BTNU;
    logic         BTND;
    logic [7:0]   SW;
    logic [3:0]   LD;
    logic [2:0]   MODE_LD;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_q[$];
    string      tag_q[$];
    bit         kind_q[$];

    always #5 clk = ~clk;

    gate_mode_unit #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .BTNU   (BTNU),
        .BTND   (BTND),
        .SW     (SW),
        .LD     (LD),
        .MODE_LD(MODE_LD)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_ld(input string tag, input logic [3:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
        kind_q.push_back(1'b0);
    endtask

    task automatic expect_mode(input string tag, input logic [2:0] v);
        exp_q.push_back({1'b0, v});
        tag_q.push_back(tag);
        kind_q.push_back(1'b1);
    endtask

    task automatic sb_drain();
        logic [3:0] e;
        string      t;
        bit         k;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            k = kind_q.pop_front();
            if (k) check(t, {1'b0, MODE_LD}, e);
            else   check(t, LD, e);
        end
    endtask

    // Wait for n rising edges, then land on the following falling edge.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        BTNU  = 1'b0;
        BTND  = 1'b0;
        SW    = 8'h00;
        edges(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input bit up);
        if (up) BTNU = 1'b1;
        else    BTND = 1'b1;
        edges(8);
        BTNU = 1'b0;
        BTND = 1'b0;
        edges(8);
    endtask

    function automatic logic [3:0] op_model(input logic [2:0] m, input logic [7:0] s);
        logic [3:0] a;
        logic [3:0] b;
        a = s[3:0];
        b = s[7:4];
        case (m)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return {3'b000, ^s};
        endcase
    endfunction

    initial begin
        logic [7:0] r;
        rst_n = 1'b1;
        BTNU  = 1'b0;
        BTND  = 1'b0;
        SW    = 8'h00;
        #1 rst_n = 1'b0;
        expect_ld("reset_ld", 4'b0000);
        expect_mode("reset_mode", 3'd0);
        #1 sb_drain();
        @(negedge clk);
        rst_n = 1'b1;

        // AND latency, then step to XOR
        SW = 8'b1100_1010;
        edges(2);
        expect_ld("s1_ld_before_3_edges", 4'b0000);
        sb_drain();
        edges(1);
        expect_ld("s1_and", 4'b1000);
        sb_drain();
        press(1'b1);
        press(1'b1);
        expect_mode("s1_mode2", 3'd2);
        expect_ld("s1_xor", 4'b0110);
        sb_drain();

        // held button: exact press latency, single step
        do_reset();
        BTNU = 1'b1;
        edges(6);
        expect_mode("s2_edge6", 3'd0);
        sb_drain();
        edges(1);
        expect_mode("s2_edge7", 3'd1);
        sb_drain();
        edges(13);
        expect_mode("s2_held", 3'd1);
        sb_drain();
        BTNU = 1'b0;
        edges(6);
        BTNU = 1'b1;
        edges(10);
        expect_mode("s2_second_press", 3'd2);
        sb_drain();
        BTNU = 1'b0;
        edges(8);

        // bounce shorter than the debounce window
        do_reset();
        BTNU = 1'b1;
        edges(3);
        BTNU = 1'b0;
        edges(1);
        BTNU = 1'b1;
        edges(3);
        BTNU = 1'b0;
        edges(12);
        expect_mode("s3_bounce", 3'd0);
        sb_drain();

        // wrap both ways, simultaneous presses
        do_reset();
        press(1'b0);
        expect_mode("s4_wrap_down", 3'd7);
        sb_drain();
        press(1'b1);
        expect_mode("s4_wrap_up", 3'd0);
        sb_drain();
        BTNU = 1'b1;
        BTND = 1'b1;
        edges(12);
        expect_mode("s4_both_held", 3'd0);
        sb_drain();
        BTNU = 1'b0;
        BTND = 1'b0;
        edges(10);
        expect_mode("s4_both_released", 3'd0);
        sb_drain();

        // NOT and PARITY
        do_reset();
        press(1'b0);
        press(1'b0);
        SW = 8'b1111_0101;
        edges(3);
        expect_mode("s5_mode6", 3'd6);
        expect_ld("s5_not", 4'b1010);
        sb_drain();
        press(1'b1);
        SW = 8'b0000_0111;
        edges(3);
        expect_ld("s5_parity_odd", 4'b0001);
        sb_drain();
        SW = 8'b0000_0011;
        edges(3);
        expect_ld("s5_parity_even", 4'b0000);
        sb_drain();

        // sweep every mode with random operands
        for (int i = 0; i < 8; i++) begin
            press(1'b1);
            expect_mode($sformatf("sweep_mode%0d", i), 3'(i));
            sb_drain();
            for (int j = 0; j < 3; j++) begin
                r  = 8'($urandom_range(0, 255));
                SW = r;
                edges(3);
                expect_ld($sformatf("sweep_m%0d_sw%02h", i, r), op_model(3'(i), r));
                sb_drain();
            end
        end

        // asynchronous reset mid-debounce, button held through release
        do_reset();
        repeat (5) press(1'b1);
        SW = 8'h00;
        edges(3);
        expect_mode("s6_mode5", 3'd5);
        expect_ld("s6_xnor_zero", 4'b1111);
        sb_drain();
        BTNU = 1'b1;
        edges(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        expect_ld("s6_async_ld", 4'b0000);
        expect_mode("s6_async_mode", 3'd0);
        #1 sb_drain();
        @(negedge clk);
        rst_n = 1'b1;
        edges(6);
        expect_mode("s6_edge6", 3'd0);
        sb_drain();
        edges(1);
        expect_mode("s6_edge7", 3'd1);
        sb_drain();
        BTNU = 1'b0;
        edges(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gate_mode_unit.md
# gate_mode_unit

- Parametrised, clocked successor to the board's fixed switch-to-LED gate logic.
- Applies one of eight selectable bitwise logic operations to two WIDTH-bit switch operands and drives the result onto registered LEDs.
- Two debounced push-buttons step the operation mode up and down; the current mode is shown on three LEDs.
- Sits at the board top level, directly between the pad inputs (buttons, switches) and the LED outputs.

## Interface

- WIDTH, 4: operand width. Switch bus is 2*WIDTH bits. Minimum 1.
- DEBOUNCE_CYCLES, 1000000: number of consecutive stable cycles required to accept a button level (10 ms at 100 MHz). Minimum 2.
- clk  input  1  system clock.
- rst_n  input  1  reset. Asynchronous, active-low.
- BTNU  input  1  raw button: mode +1.
- BTND  input  1  raw button: mode −1.
- SW  input  2*WIDTH  raw switches. A = SW[WIDTH-1:0], B = SW[2*WIDTH-1:WIDTH].
- LD  output  WIDTH  registered operation result.
- MODE_LD  output  3  registered current mode.

## Operation

- **Switch synchronisation:** SW passes through a 2-flop synchroniser. Switches are not debounced.
- **Button conditioning:** each button has its own 2-flop synchroniser followed by a debouncer.
  - The debouncer holds a stable level q and a counter cnt.
  - While the synchronised level s equals q: cnt is held at 0.
  - While s differs from q: cnt increments. When cnt reaches DEBOUNCE_CYCLES-1 with s still different from q, q takes the value of s and cnt returns to 0.
  - Any return of s to q before that point clears cnt, so partial bounces are discarded.
- **Press detection:** a press is a rising edge of q, produced as a one-cycle pulse (q & ~q_prev). Releases produce no event.
- **Mode register (3 bits):**
  - Up pulse alone: mode+1 mod 8, so 7 wraps to 0.
  - Down pulse alone: mode−1 mod 8, so 0 wraps to 7.
  - Both pulses in the same cycle: no change.
- **Modes** (with A and B taken from the synchronised switches):
  - 0 AND: A&B.
  - 1 OR: A|B.
  - 2 XOR: A^B.
  - 3 NAND: ~(A&B).
  - 4 NOR: ~(A|B).
  - 5 XNOR: ~(A^B).
  - 6 NOT: ~A (B ignored).
  - 7 PARITY: LD[0] = XOR-reduction of all 2*WIDTH bits; LD[WIDTH-1:1] = 0.
- **Outputs:** LD is registered from the mode and synchronised operands. MODE_LD is the mode register itself.
- **Reset:** all flops clear: synchronisers, debouncer q and cnt, q_prev, mode, LD.
  - LD = 0 and MODE_LD = 0 immediately on rst_n falling, independent of clk.
  - A button held through reset release must be stable for DEBOUNCE_CYCLES cycles before it registers one press.

## Timing

- **Switch to LD latency:** SW sampled at edge 0 appears on LD after edge 3 (2 sync + 1 output register).
- **Button to MODE_LD latency:**
  - Raw button high sampled at edge 0 and held.
  - Synchronised s is high after edge 2.
  - q rises after edge 2+DEBOUNCE_CYCLES, and the press pulse is high in that cycle.
  - MODE_LD updates after edge 3+DEBOUNCE_CYCLES.
  - LD reflects the new mode after edge 4+DEBOUNCE_CYCLES.
- **Held button:** exactly one mode step per press, however long the button is held.
- **Short pulses:** a raw pulse shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produces no step.
- **Release debounce:** a release must also be stable for DEBOUNCE_CYCLES cycles before a new press is accepted.
- **Counter width:** $clog2(DEBOUNCE_CYCLES). cnt never exceeds DEBOUNCE_CYCLES-1.

## Structure

- **Shared package gate_pkg:**
  - mode localparams MODE_AND=0 … MODE_PARITY=7.
  - MODE_W=3.
- **Sub-module debouncer:** parameter DEBOUNCE_CYCLES; ports clk, rst_n, din (raw), q (stable level), rise (one-cycle pulse). It contains both the synchroniser and the edge detector, and is instantiated twice.
- **Top level:** the top contains the switch synchroniser, mode register and registered output mux.

## Test plan

All scenarios use WIDTH=4 and DEBOUNCE_CYCLES=4.

1. Mode 0, SW=8'b1100_1010 → LD=4'b1000 exactly 3 edges after SW changes. Switch to mode 2 → LD=4'b0110.
2. BTNU held 20 cycles from reset state → MODE_LD=1 exactly after edge 7 from first sample and stays 1. Release, wait 6 cycles, press again → MODE_LD=2.
3. BTNU bounce (high 3 cycles, low 1, high 3, low) → MODE_LD unchanged at 0.
4. Wrap cases:
   - From mode 7, one BTNU press → MODE_LD=0.
   - From mode 0, one BTND press → MODE_LD=7.
   - BTNU and BTND asserted on the same edge and held → MODE_LD unchanged.
5. Mode 6 with SW=8'b1111_0101 → LD=4'b1010. Mode 7 with SW=8'b0000_0111 → LD=4'b0001. Mode 7 with SW=8'b0000_0011 → LD=4'b0000.
6. In mode 5 with BTNU mid-debounce, rst_n pulled low between clock edges → LD=0 and MODE_LD=0 before the next edge. After release with BTNU still held → one step to mode 1 after 7 edges.
